instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/instr_queue_fifo.sv | 69 ++++++
 rtl/instr_fetch_queue.sv | 92 +++++++++
 tb/tb_instr_fetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the instruction fetch front end.
// Provides word/instruction sizing constants, the default ROM size and the
// packed queue-entry type ({pc, instr}, 64 bits) used by the fetch queue.
package tomasulo_pkg;

    localparam int WORD_W            = 32;
    localparam int INSTR_BYTES       = 4;
    localparam int ROM_BYTES_DEFAULT = 100;
    localparam int ENTRY_W           = 64;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue_fifo.sv
// Circular instruction queue: DEPTH entries of {pc, instr}.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (control state only)
//   push          - write wr_entry at the tail on the rising edge
//   pop           - advance the head on the rising edge (caller ensures non-empty)
//   flush         - empty the queue; overrides push and pop
//   wr_entry      - entry to enqueue
//   rd_entry      - entry currently at the head (meaningless when count == 0)
//   count         - current occupancy, 0..DEPTH
module instr_queue_fifo
    import tomasulo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wr_entry,
    output fetch_entry_t       rd_entry,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so plain increment wraps the pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale slots are never visible because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: walks a PC through an instruction ROM and buffers
// fetched {pc, instr} pairs in a small queue for the issue stage.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   romNrd, romAddr, romData   - ROM read strobe (active low), byte address (= PC),
//                                combinational big-endian instruction word
//   issueValid/Instr/Pc/Ready  - queue head handshake towards issue
//   redirectValid, redirectPc  - flush queue and restart fetch at redirectPc (word aligned)
//   fetchDone                  - PC is past the last full word of the ROM
//   queueCount                 - current queue occupancy
module instr_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter  int                DEPTH     = 4,
    parameter  logic [WORD_W-1:0] PC_RESET  = 32'h0,
    parameter  int                ROM_BYTES = ROM_BYTES_DEFAULT,
    localparam int                CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              romNrd,
    output logic [WORD_W-1:0] romAddr,
    input  logic [WORD_W-1:0] romData,
    output logic              issueValid,
    output logic [WORD_W-1:0] issueInstr,
    output logic [WORD_W-1:0] issuePc,
    input  logic              issueReady,
    input  logic              redirectValid,
    input  logic [WORD_W-1:0] redirectPc,
    output logic              fetchDone,
    output logic [CNT_W-1:0]  queueCount
);

    localparam logic [WORD_W-1:0] LAST_WORD_ADDR = WORD_W'(ROM_BYTES - INSTR_BYTES);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  q_count;
    logic              fetch_en;
    logic              pop;
    logic              has_room;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              unused_redirect_lsbs;

    assign fetchDone = pc_q > LAST_WORD_ADDR;
    assign has_room  = q_count < CNT_W'(DEPTH);

    // Redirect hides the head so nothing is consumed in the flush cycle.
    assign issueValid = (q_count != '0) && !redirectValid;
    assign pop        = issueValid && issueReady;

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign fetch_en = !rst && !redirectValid && !fetchDone && (has_room || pop);

    assign romNrd  = !fetch_en;
    assign romAddr = pc_q;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = romData;

    always_comb begin
        pc_d = pc_q;
        if (redirectValid)  pc_d = {redirectPc[WORD_W-1:2], 2'b00};
        else if (fetch_en)  pc_d = pc_q + WORD_W'(INSTR_BYTES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= PC_RESET;
        else     pc_q <= pc_d;
    end

    instr_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (fetch_en),
        .pop      (pop),
        .flush    (redirectValid),
        .wr_entry (push_entry),
        .rd_entry (head_entry),
        .count    (q_count)
    );

    assign issueInstr = head_entry.instr;
    assign issuePc    = head_entry.pc;
    assign queueCount = q_count;

    // Redirect targets are forced word-aligned; the low bits are intentionally dropped.
    assign unused_redirect_lsbs = ^redirectPc[1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue (DEPTH=4, PC_RESET=0, ROM_BYTES=100).
module tb_instr_fetch_queue;

    localparam int DEPTH     = 4;
    localparam int ROM_BYTES = 100;
    localparam int CNT_W     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              romNrd;
    logic [31:0]       romAddr;
    logic [31:0]       romData;
    logic              issueValid;
    logic [31:0]       issueInstr;
    logic [31:0]       issuePc;
    logic              issueReady = 1'b0;
    logic              redirectValid = 1'b0;
    logic [31:0]       redirectPc = 32'h0;
    logic              fetchDone;
    logic [CNT_W-1:0]  queueCount;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: in-order list of buffered (pc,instr) and the fetch PC.
    logic [63:0] mq[$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    assign romData = rom_word(romAddr);

    instr_fetch_queue #(
        .DEPTH     (DEPTH),
        .PC_RESET  (32'h0),
        .ROM_BYTES (ROM_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .romNrd        (romNrd),
        .romAddr       (romAddr),
        .romData       (romData),
        .issueValid    (issueValid),
        .issueInstr    (issueInstr),
        .issuePc       (issuePc),
        .issueReady    (issueReady),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .fetchDone     (fetchDone),
        .queueCount    (queueCount)
    );

    // Leaves the bench at a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        issueReady = 1'b0;
        redirectValid = 1'b0;
        redirectPc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mpc = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (romNrd !== 1'b1) begin tests_failed++; $display("FAIL reset_romNrd got %0b want 1", romNrd); end
        tests_run++;
        if (issueValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", issueValid); end
        tests_run++;
        if (queueCount !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", queueCount); end
        tests_run++;
        if (romAddr !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", romAddr); end
        tests_run++;
        if (fetchDone !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", fetchDone); end
    endtask

    task automatic test_in_order();
        do_reset();
        issueReady = 1'b1;
        #1;
        tests_run++;
        if (issueValid !== 1'b0) begin tests_failed++; $display("FAIL first_cycle_valid got %0b want 0", issueValid); end
        tests_run++;
        if (romNrd !== 1'b0) begin tests_failed++; $display("FAIL first_cycle_romNrd got %0b want 0", romNrd); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (issueValid !== 1'b1 || issuePc !== 32'(4 * k) || issueInstr !== rom_word(32'(4 * k))) begin
                tests_failed++;
                $display("FAIL in_order_%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         k, issueValid, issuePc, issueInstr, 4 * k, rom_word(32'(4 * k)));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        issueReady = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        tests_run++;
        if (queueCount !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d want 4", queueCount); end
        tests_run++;
        if (romNrd !== 1'b1) begin tests_failed++; $display("FAIL full_romNrd got %0b want 1", romNrd); end
        tests_run++;
        if (romAddr !== 32'd16) begin tests_failed++; $display("FAIL full_pc got %0d want 16", romAddr); end
        issueReady = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (queueCount !== 3'd4 || romNrd !== 1'b0 || issuePc !== 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL full_stream_%0d got cnt=%0d nrd=%0b pc=%h want cnt=4 nrd=0 pc=%h",
                         k, queueCount, romNrd, issuePc, 4 * k);
            end
            @(negedge clk);
            #1;
        end
        tests_run++;
        if (issuePc !== 32'd16 || romAddr !== 32'd32) begin
            tests_failed++;
            $display("FAIL full_after_stream got pc=%h addr=%h want pc=10 addr=20", issuePc, romAddr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        issueReady = 1'b0;
        repeat (4) @(negedge clk);
        issueReady = 1'b1;
        repeat (2) @(negedge clk);
        issueReady = 1'b0;
        #1;
        tests_run++;
        if (issuePc !== 32'd8 || queueCount !== 3'd4 || romAddr !== 32'd24) begin
            tests_failed++;
            $display("FAIL redir_setup got pc=%h cnt=%0d addr=%h want pc=8 cnt=4 addr=18", issuePc, queueCount, romAddr);
        end
        redirectValid = 1'b1;
        redirectPc = 32'h2E;
        #1;
        tests_run++;
        if (issueValid !== 1'b0 || romNrd !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_cycle got v=%0b nrd=%0b want v=0 nrd=1", issueValid, romNrd);
        end
        @(negedge clk);
        redirectValid = 1'b0;
        #1;
        tests_run++;
        if (queueCount !== 3'd0 || romAddr !== 32'h2C || issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_after got cnt=%0d addr=%h v=%0b want cnt=0 addr=2c v=0", queueCount, romAddr, issueValid);
        end
        @(negedge clk);
        issueReady = 1'b1;
        #1;
        tests_run++;
        if (issueValid !== 1'b1 || issuePc !== 32'h2C || issueInstr !== rom_word(32'h2C)) begin
            tests_failed++;
            $display("FAIL redir_first_issue got v=%0b pc=%h ins=%h want v=1 pc=2c ins=%h",
                     issueValid, issuePc, issueInstr, rom_word(32'h2C));
        end
    endtask

    task automatic test_end_of_rom();
        logic [31:0] last_pc;
        bit          reached;
        do_reset();
        issueReady = 1'b1;
        last_pc = 32'hFFFF_FFFF;
        reached = 1'b0;
        for (int cyc = 0; cyc < 80 && !reached; cyc++) begin
            @(negedge clk);
            #1;
            if (issueValid) last_pc = issuePc;
            if (fetchDone && queueCount == 3'd0) reached = 1'b1;
        end
        tests_run++;
        if (!reached) begin tests_failed++; $display("FAIL eor_timeout got not-drained want drained within 80 cycles"); end
        tests_run++;
        if (last_pc !== 32'd96) begin tests_failed++; $display("FAIL eor_last_pc got %0d want 96", last_pc); end
        tests_run++;
        if (romAddr !== 32'd100 || fetchDone !== 1'b1 || romNrd !== 1'b1 || queueCount !== 3'd0) begin
            tests_failed++;
            $display("FAIL eor_state got addr=%0d done=%0b nrd=%0b cnt=%0d want 100 1 1 0",
                     romAddr, fetchDone, romNrd, queueCount);
        end
        redirectValid = 1'b1;
        redirectPc = 32'h40;
        @(negedge clk);
        redirectValid = 1'b0;
        #1;
        tests_run++;
        if (fetchDone !== 1'b0 || romAddr !== 32'h40 || romNrd !== 1'b0) begin
            tests_failed++;
            $display("FAIL eor_redirect got done=%0b addr=%h nrd=%0b want 0 40 0", fetchDone, romAddr, romNrd);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        issueReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (queueCount !== 3'd3) begin tests_failed++; $display("FAIL areset_pre_count got %0d want 3", queueCount); end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (queueCount !== 3'd0 || issueValid !== 1'b0 || romNrd !== 1'b1 || romAddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL areset_immediate got cnt=%0d v=%0b nrd=%0b addr=%h want 0 0 1 0",
                     queueCount, issueValid, romNrd, romAddr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (queueCount !== 3'd1 || issuePc !== 32'h0 || romAddr !== 32'h4) begin
            tests_failed++;
            $display("FAIL areset_resume got cnt=%0d pc=%h addr=%h want 1 0 4", queueCount, issuePc, romAddr);
        end
    endtask

    task automatic test_random();
        bit          exp_valid, exp_done, exp_pop, exp_fetch;
        logic [63:0] head;
        int          issued;
        do_reset();
        issued = 0;
        for (int i = 0; i < 600; i++) begin
            if (i != 0) @(negedge clk);
            issueReady    = ($urandom_range(0, 9) < 7);
            redirectValid = ($urandom_range(0, 19) == 0);
            redirectPc    = 32'($urandom_range(0, 127));
            #1;
            exp_valid = (mq.size() != 0) && !redirectValid;
            exp_done  = mpc > 32'(ROM_BYTES - 4);
            exp_pop   = exp_valid && issueReady;
            exp_fetch = !redirectValid && !exp_done && ((mq.size() < DEPTH) || exp_pop);
            head      = (mq.size() != 0) ? mq[0] : 64'h0;
            tests_run++;
            if (issueValid !== exp_valid || queueCount !== CNT_W'(mq.size()) || romNrd !== !exp_fetch ||
                romAddr !== mpc || fetchDone !== exp_done) begin
                tests_failed++;
                $display("FAIL rand_ctrl_%0d got v=%0b cnt=%0d nrd=%0b addr=%h done=%0b want v=%0b cnt=%0d nrd=%0b addr=%h done=%0b",
                         i, issueValid, queueCount, romNrd, romAddr, fetchDone,
                         exp_valid, mq.size(), !exp_fetch, mpc, exp_done);
            end
            if (exp_valid) begin
                tests_run++;
                if (issuePc !== head[63:32] || issueInstr !== head[31:0]) begin
                    tests_failed++;
                    $display("FAIL rand_head_%0d got pc=%h ins=%h want pc=%h ins=%h",
                             i, issuePc, issueInstr, head[63:32], head[31:0]);
                end
            end
            @(posedge clk);
            if (redirectValid) begin
                mq.delete();
                mpc = {redirectPc[31:2], 2'b00};
            end else begin
                if (exp_pop) begin
                    void'(mq.pop_front());
                    issued++;
                end
                if (exp_fetch) begin
                    mq.push_back({mpc, rom_word(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
        tests_run++;
        if (issued < 50) begin tests_failed++; $display("FAIL rand_activity got %0d issues want >=50", issued); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_redirect();
        test_end_of_rom();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
